// File: rtl/mem_access_unit.sv
// Memory-side stage of the single-bus datapath: owns MAR and a word-addressed
// synchronous RAM with a configurable number of wait states per access.
module mem_access_unit #(
    parameter int ADDR_WIDTH  = 9,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bus,
    input  logic        MARin,
    input  logic [31:0] MDRval,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] Mdatain,
    output logic [31:0] MARval,
    output logic        mem_busy,
    output logic        mem_done,
    output logic        addr_err
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);
    localparam int         DEPTH     = 1 << ADDR_WIDTH;

    state_t                state;
    state_t                state_nx;
    logic [3:0]            cnt;
    logic                  acc_wr;
    logic [31:0]           acc_addr;
    logic [31:0]           acc_wdata;
    logic                  start;
    logic                  fire;
    logic                  in_range;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [31:0]           ram [0:DEPTH-1];

    // Upper address bits must be zero; out-of-range addresses are flagged, never folded.
    assign in_range = (acc_addr >> ADDR_WIDTH) == 32'd0;
    assign ram_idx  = acc_addr[ADDR_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and status outputs; requests outside IDLE are simply dropped.
    always_comb begin
        state_nx = state;
        start    = 1'b0;
        fire     = 1'b0;
        mem_busy = 1'b0;
        mem_done = 1'b0;
        addr_err = 1'b0;
        case (state)
            IDLE: begin
                if (mem_read ^ mem_write) begin
                    start    = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (cnt == 4'd0) begin
                    fire     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                mem_busy = 1'b1;
                mem_done = 1'b1;
                addr_err = ~in_range;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // MAR follows the bus whenever MARin is high, independent of access state.
    always_ff @(posedge clk) begin
        if (reset)      MARval <= 32'd0;
        else if (MARin) MARval <= bus;
    end

    // Wait counter and latched operation for the access in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= 4'd0;
            acc_wr <= 1'b0;
        end else if (start) begin
            cnt    <= WAIT_INIT;
            acc_wr <= mem_write;
        end else if (state == WAIT && cnt != 4'd0) begin
            cnt    <= cnt - 4'd1;
        end
    end

    // Address and write data snapshot at request time, so later MAR/MDR changes do not leak in.
    always_ff @(posedge clk) begin
        if (start) begin
            acc_addr  <= MARval;
            acc_wdata <= MDRval;
        end
    end

    // RAM write port; a reset on the access edge aborts the write.
    always_ff @(posedge clk) begin
        if (fire && acc_wr && in_range && !reset)
            ram[ram_idx] <= acc_wdata;
    end

    // Read data register; holds until the next completed read or reset.
    always_ff @(posedge clk) begin
        if (reset)
            Mdatain <= 32'd0;
        else if (fire && !acc_wr)
            Mdatain <= in_range ? ram[ram_idx] : 32'd0;
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: scoreboard of expected completions,
// plus a second instance with zero wait states for the latency checks.
module tb_mem_access_unit;

    localparam int AW = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bus;
    logic        MARin;
    logic [31:0] MDRval;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mdat,  marv;
    logic        busy,  done,  err;
    logic [31:0] mdat0, marv0;
    logic        busy0, done0, err0;

    mem_access_unit #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) u_dut (
        .clk(clk), .reset(reset), .bus(bus), .MARin(MARin), .MDRval(MDRval),
        .mem_read(mem_read), .mem_write(mem_write), .Mdatain(mdat), .MARval(marv),
        .mem_busy(busy), .mem_done(done), .addr_err(err)
    );

    mem_access_unit #(.ADDR_WIDTH(AW), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .bus(bus), .MARin(MARin), .MDRval(MDRval),
        .mem_read(mem_read), .mem_write(mem_write), .Mdatain(mdat0), .MARval(marv0),
        .mem_busy(busy0), .mem_done(done0), .addr_err(err0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] dat;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mem_m [logic [31:0]];
    logic [31:0] last_rd;
    logic [31:0] mar_m;
    int          vectors = 0;
    int          miscompares = 0;
    int          cycnt = 0;
    int          cyc;
    int          done_cyc;
    int          t1;

    always @(posedge clk) cycnt <= cycnt + 1;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one access given the address it will use.
    function automatic logic [31:0] predict(input bit wr, input logic [31:0] a,
                                            input logic [31:0] d, output logic er);
        er = (a >> AW) != 32'd0;
        if (wr) begin
            if (!er) mem_m[a] = d;
            return last_rd;
        end
        if (er)                last_rd = 32'd0;
        else if (mem_m.exists(a)) last_rd = mem_m[a];
        else                   last_rd = 32'hxxxxxxxx;
        return last_rd;
    endfunction

    task automatic load_mar(input logic [31:0] v);
        bus   = v;
        MARin = 1'b1;
        tick();
        MARin = 1'b0;
        mar_m = v;
    endtask

    // Drive a one-cycle request in the current cycle and queue its expected result.
    task automatic start_req(input bit wr);
        exp_t e;
        logic er;
        e.dat = predict(wr, mar_m, MDRval, er);
        e.err = er;
        sb.push_back(e);
        mem_write = wr;
        mem_read  = ~wr;
        tick();
        mem_write = 1'b0;
        mem_read  = 1'b0;
        MARin     = 1'b0;
        cyc       = 1;
    endtask

    // Wait (bounded) for mem_done, then pop and compare the expected result.
    task automatic finish_req(input string tag, input int exp_lat);
        exp_t e;
        while (done !== 1'b1 && cyc < 40) begin
            check({tag, "_busy"}, busy, 1);
            tick();
            cyc++;
        end
        check({tag, "_lat"}, cyc, exp_lat);
        done_cyc = cycnt;
        check({tag, "_sb"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_data"}, mdat, e.dat);
            check({tag, "_err"}, err, e.err);
        end
        check({tag, "_busy_done"}, busy, 1);
        tick();
        check({tag, "_done_1cyc"}, done, 0);
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset = 1'b1; bus = 32'd0; MARin = 1'b0; MDRval = 32'd0;
        mem_read = 1'b0; mem_write = 1'b0;
        mar_m = 32'd0; last_rd = 32'd0;
        tick(); tick();
        check("rst_mdat", mdat, 0);
        check("rst_mar", marv, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_mdat0", mdat0, 0);
        reset = 1'b0;
        tick();

        // Write then read back at 0x55.
        load_mar(32'h55);
        check("mar_load", marv, 32'h55);
        MDRval = 32'h12345678;
        start_req(1'b1);
        finish_req("wr55", 4);
        start_req(1'b0);
        finish_req("rd55", 4);

        // Populate a few more words.
        load_mar(32'h01); MDRval = 32'h11111111; start_req(1'b1); finish_req("wr01", 4);
        load_mar(32'h02); MDRval = 32'h22222222; start_req(1'b1); finish_req("wr02", 4);
        load_mar(32'h00); MDRval = 32'hCAFEF00D; start_req(1'b1); finish_req("wr00", 4);

        // Read re-pulsed during WAIT is dropped.
        load_mar(32'h55);
        start_req(1'b0);
        mem_read = 1'b1;
        tick();
        mem_read = 1'b0;
        cyc = 2;
        finish_req("repulse", 4);
        for (int i = 0; i < 4; i++) begin
            check("repulse_no_2nd", done, 0);
            tick();
        end

        // Both requests high together is ignored.
        mem_read = 1'b1; mem_write = 1'b1;
        tick();
        mem_read = 1'b0; mem_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("both_busy", busy, 0);
            check("both_done", done, 0);
            tick();
        end

        // MAR reload during WAIT does not affect the in-flight read.
        load_mar(32'h02);
        start_req(1'b0);
        bus = 32'h10; MARin = 1'b1;
        tick();
        MARin = 1'b0; mar_m = 32'h10; cyc = 2;
        check("mar_wait_val", marv, 32'h10);
        finish_req("mar_wait", 4);

        // Request on the same edge as MARin uses the old MAR.
        load_mar(32'h01);
        bus = 32'h02; MARin = 1'b1;
        start_req(1'b0);
        mar_m = 32'h02;
        check("mar_same_edge", marv, 32'h02);
        finish_req("same_edge", 4);

        // Zero-wait latency on the second instance (Mdatain reset to 0 first).
        reset = 1'b1; tick(); reset = 1'b0; last_rd = 32'd0; mar_m = 32'd0;
        load_mar(32'h55);
        check("w0_c0_busy", busy0, 0);
        start_req(1'b0);
        check("w0_c1_busy", busy0, 1);
        check("w0_c1_done", done0, 0);
        check("w0_c1_mdat", mdat0, 0);
        tick(); cyc = 2;
        check("w0_c2_busy", busy0, 1);
        check("w0_c2_done", done0, 1);
        check("w0_c2_mdat", mdat0, 32'h12345678);
        check("w0_c2_err", err0, 0);
        tick(); cyc = 3;
        check("w0_c3_busy", busy0, 0);
        check("w0_c3_done", done0, 0);
        finish_req("rd55_w2", 4);

        // Out-of-range write is flagged and leaves RAM alone.
        load_mar(32'h200); MDRval = 32'hDEADBEEF; start_req(1'b1); finish_req("oor_wr", 4);
        load_mar(32'h000); start_req(1'b0); finish_req("rd000", 4);
        load_mar(32'h200); start_req(1'b0); finish_req("oor_rd", 4);

        // Reset in the middle of a write aborts it.
        load_mar(32'h07); MDRval = 32'hAAAAAAAA; start_req(1'b1); finish_req("wr07", 4);
        MDRval = 32'h55555555;
        mem_write = 1'b1;
        tick();
        mem_write = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        check("abort_mdat", mdat, 0);
        check("abort_mar", marv, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        reset = 1'b0; last_rd = 32'd0; mar_m = 32'd0;
        tick();
        tick();
        check("abort_idle", busy, 0);
        load_mar(32'h07); start_req(1'b0); finish_req("rd07", 4);

        // Back-to-back reads, second issued the cycle after DONE.
        load_mar(32'h01);
        start_req(1'b0);
        bus = 32'h02; MARin = 1'b1;
        tick();
        MARin = 1'b0; mar_m = 32'h02; cyc = 2;
        finish_req("b2b1", 4);
        t1 = done_cyc;
        start_req(1'b0);
        finish_req("b2b2", 4);
        check("b2b_spacing", done_cyc - t1, 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-side stage of the single-bus datapath; sits beside MAR/MDR.
- Owns the MAR register, which captures the bus, plus a word-addressed synchronous RAM with a configurable wait-state count.
- Write data comes from MDRval. Read data drives Mdatain into the datapath's MDR input mux.
- The control unit starts accesses with single-cycle read/write requests and waits for mem_done before asserting MDRin.

Parameters:
- ADDR_WIDTH, 9, word-address bits used from MAR; RAM depth = 2**ADDR_WIDTH words of 32 bits.
- WAIT_CYCLES, 2, extra wait states per access; legal range 0..15.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- bus  input  32  datapath bus; source for MAR.
- MARin  input  1  loads MAR from bus at the clock edge.
- MDRval  input  32  MDR contents; write data.
- mem_read  input  1  read request, sampled in IDLE.
- mem_write  input  1  write request, sampled in IDLE.
- Mdatain  output  32  read data to the MDR input mux.
- MARval  output  32  current MAR contents.
- mem_busy  output  1  high while an access is in flight (WAIT or DONE).
- mem_done  output  1  one-cycle completion pulse.
- addr_err  output  1  high together with mem_done when the completed access was out of range.

Behaviour:
- Reset (synchronous, takes priority over everything):
  - state=IDLE; MARval, Mdatain and wait counter = 0; mem_busy, mem_done, addr_err = 0.
  - RAM contents are not cleared.
- MAR:
  - MARin=1 loads bus at the edge, in any state, including while busy.
  - An in-flight access uses its latched address, not the new MAR value.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - Exactly one of mem_read/mem_write high at the edge: latch MARval as access address, latch MDRval as write data, latch op, cnt<=WAIT_CYCLES, go to WAIT.
  - A request sampled in the same edge as MARin uses the old MAR value.
  - Both requests high: illegal. Ignored; no state change, no done.
  - Neither high: stay in IDLE.
- WAIT:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: perform the access at this edge and go to DONE.
  - Requests arriving during WAIT/DONE are dropped; no queueing.
- Access, in range (latched address bits [31:ADDR_WIDTH] all zero):
  - Read: Mdatain<=RAM[addr].
  - Write: RAM[addr]<=write data; Mdatain unchanged.
- Access, out of range (any of those bits nonzero):
  - No RAM write.
  - A read sets Mdatain<=0.
  - addr_err=1 during DONE.
- DONE: mem_done=1 and mem_busy=1 for exactly one cycle, then go to IDLE. A new request may be sampled in the cycle after DONE.
- Latency:
  - Request high in cycle 0 → WAIT occupies cycles 1..WAIT_CYCLES+1 → mem_done in cycle WAIT_CYCLES+2.
  - mem_busy is high in cycles 1..WAIT_CYCLES+2.
- Mdatain hold: Mdatain is registered and holds its value until the next completed read or reset. It is valid from the DONE cycle onward.
- Reset mid-access: the access is aborted, no RAM write occurs, and the FSM returns to IDLE.
- Address wrap: none. Out-of-range addresses are flagged, never folded.

Test Plan:
- WAIT_CYCLES=2, write then read:
  - MARin with bus=0x55; MDRval=0x12345678; pulse mem_write in cycle 0 → mem_done in cycle 4, addr_err=0.
  - Then mem_read → mem_done 4 cycles later, Mdatain=0x12345678.
- Latency at WAIT_CYCLES=0 (cycles counted from the mem_read request cycle):
  - mem_done in cycle 2.
  - mem_busy high in cycles 1–2 only.
  - Mdatain changes exactly at the edge entering DONE.
- Out of range:
  - MAR=0x00000200 (ADDR_WIDTH=9), mem_write with MDRval=0xDEADBEEF → addr_err=1 with mem_done.
  - Read of address 0x000 returns its prior value (RAM not corrupted).
  - Read of 0x200 → Mdatain=0, addr_err=1.
- Busy/illegal requests:
  - mem_read re-pulsed during WAIT → ignored; exactly one mem_done.
  - mem_read and mem_write both high in IDLE → no busy, no done.
  - MARin=1 with bus=0x10 during WAIT → MARval=0x10, but the data returned comes from the original address.
- Reset mid-write:
  - Write 0xAAAAAAAA to 0x07 completes.
  - Start a write of 0x55555555 to 0x07 and assert reset in cycle 2 → all outputs 0 next cycle, state IDLE.
  - Subsequent read of 0x07 returns 0xAAAAAAAA.
- Back-to-back: request in the cycle after DONE is accepted; two sequential reads of 0x01 and 0x02 each complete with correct data, mem_done spaced WAIT_CYCLES+3 cycles apart.
